// File: rtl/dpi_stream_sequencer_pkg.sv
// Shared types and defaults for the DPI stream sequencer: FSM state encoding,
// default widths/gaps and a saturating counter helper.
package dpi_stream_sequencer_pkg;

  localparam int DEF_NUM_RULES = 8;
  localparam int DEF_KEY_W     = 32;
  localparam int DEF_SID_W     = 6;
  localparam int DEF_LOAD_GAP  = 2;
  localparam int DEF_EOP_GAP   = 2;
  localparam int GAP_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_LOAD   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STREAM = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_EOP    = 3'd6,
    ST_RESULT = 3'd7
  } seq_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dpi_stream_sequencer_if.sv
// Packet ingress and result egress handshakes of the stream sequencer.
// master = upstream source / result consumer, slave = sequencer.
interface dpi_stream_sequencer_if #(
  parameter int KEY_W     = 32,
  parameter int SID_W     = 6,
  parameter int NUM_RULES = 8
);
  logic                 pkt_vld;
  logic                 pkt_rdy;
  logic [7:0]           pkt_data;
  logic                 pkt_sop;
  logic                 pkt_eop;
  logic [KEY_W-1:0]     pkt_key;

  logic                 res_vld;
  logic                 res_rdy;
  logic [SID_W-1:0]     res_stream_id;
  logic                 res_new;
  logic [NUM_RULES-1:0] res_fired;

  modport master (
    output pkt_vld, pkt_data, pkt_sop, pkt_eop, pkt_key, res_rdy,
    input  pkt_rdy, res_vld, res_stream_id, res_new, res_fired
  );

  modport slave (
    input  pkt_vld, pkt_data, pkt_sop, pkt_eop, pkt_key, res_rdy,
    output pkt_rdy, res_vld, res_stream_id, res_new, res_fired
  );
endinterface

// File: rtl/dpi_stream_sequencer_flow_table.sv
// Flow-key table: fully parallel key compare over 2**SID_W entries with
// round-robin allocation; on a miss the entry at alloc_ptr is (re)written.
module dpi_stream_sequencer_flow_table #(
  parameter int KEY_W = 32,
  parameter int SID_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key,
  input  logic             lookup,
  output logic             hit,
  output logic [SID_W-1:0] hit_idx,
  output logic [SID_W-1:0] alloc_ptr,
  output logic             full
);
  localparam int DEPTH = 1 << SID_W;

  logic [KEY_W-1:0] keys [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [SID_W-1:0] alloc_ptr_reg;
  logic [DEPTH-1:0] match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match[gi] = valid_reg[gi] && (keys[gi] == key);
    end
  endgenerate

  // A key is only ever written on a miss, so at most one entry can match.
  always_comb begin
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = SID_W'(i);
    end
  end

  assign hit       = |match;
  assign alloc_ptr = alloc_ptr_reg;
  assign full      = &valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg     <= '0;
      alloc_ptr_reg <= '0;
    end else if (lookup && !hit) begin
      valid_reg[alloc_ptr_reg] <= 1'b1;
      alloc_ptr_reg            <= alloc_ptr_reg + SID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (lookup && !hit) keys[alloc_ptr_reg] <= key;
  end

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Front end for the per-stream regex matchers: maps a flow key to a stream_id,
// sequences load_state / chars / eop into the matchers and returns one result per packet.
module dpi_stream_sequencer
  import dpi_stream_sequencer_pkg::*;
#(
  parameter int NUM_RULES = DEF_NUM_RULES,
  parameter int KEY_W     = DEF_KEY_W,
  parameter int SID_W     = DEF_SID_W,
  parameter int LOAD_GAP  = DEF_LOAD_GAP,
  parameter int EOP_GAP   = DEF_EOP_GAP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpi_stream_sequencer_if.slave bus,
  output logic                 load_state,
  output logic [SID_W-1:0]     stream_id,
  output logic                 new_stream_id,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  input  logic [NUM_RULES-1:0] fired_in,
  output logic                 table_full,
  output logic [15:0]          drop_cnt
);

  seq_state_t           state_reg, state_next;
  logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;
  logic [KEY_W-1:0]     key_reg;
  logic [SID_W-1:0]     stream_id_reg;
  logic                 new_reg;
  logic [7:0]           char_reg;
  logic                 char_vld_reg;
  logic [SID_W-1:0]     res_sid_reg;
  logic                 res_new_reg;
  logic [NUM_RULES-1:0] res_fired_reg;
  logic [15:0]          drop_cnt_reg;

  logic beat_rdy, res_valid, take_key, lookup, take_char, capture_res, drop_beat;
  logic             ft_hit;
  logic [SID_W-1:0] ft_hit_idx;
  logic [SID_W-1:0] ft_alloc_ptr;
  logic             ft_full;

  dpi_stream_sequencer_flow_table #(
    .KEY_W (KEY_W),
    .SID_W (SID_W)
  ) u_flow_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key_reg),
    .lookup    (lookup),
    .hit       (ft_hit),
    .hit_idx   (ft_hit_idx),
    .alloc_ptr (ft_alloc_ptr),
    .full      (ft_full)
  );

  // WAIT lasts LOAD_GAP-1 cycles: the char register adds the final idle cycle,
  // so matchers see exactly LOAD_GAP cycles between load_state and the first char.
  always_comb begin
    state_next   = state_reg;
    gap_cnt_next = gap_cnt_reg;
    beat_rdy     = 1'b0;
    res_valid    = 1'b0;
    load_state   = 1'b0;
    eop          = 1'b0;
    take_key     = 1'b0;
    lookup       = 1'b0;
    take_char    = 1'b0;
    capture_res  = 1'b0;
    drop_beat    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.pkt_vld) begin
          if (bus.pkt_sop) begin
            take_key   = 1'b1;
            state_next = ST_LOOKUP;
          end else begin
            beat_rdy  = 1'b1;
            drop_beat = 1'b1;
          end
        end
      end
      ST_LOOKUP: begin
        lookup     = 1'b1;
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_state   = 1'b1;
        gap_cnt_next = '0;
        state_next   = (LOAD_GAP > 1) ? ST_WAIT : ST_STREAM;
      end
      ST_WAIT: begin
        if (gap_cnt_reg == GAP_W'(LOAD_GAP - 2)) state_next = ST_STREAM;
        else gap_cnt_next = gap_cnt_reg + GAP_W'(1);
      end
      ST_STREAM: begin
        beat_rdy = 1'b1;
        if (bus.pkt_vld) begin
          take_char = 1'b1;
          if (bus.pkt_eop) begin
            gap_cnt_next = '0;
            state_next   = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (gap_cnt_reg == GAP_W'(EOP_GAP - 1)) state_next = ST_EOP;
        else gap_cnt_next = gap_cnt_reg + GAP_W'(1);
      end
      ST_EOP: begin
        eop         = 1'b1;
        capture_res = 1'b1;
        state_next  = ST_RESULT;
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        if (bus.res_rdy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      gap_cnt_reg   <= '0;
      key_reg       <= '0;
      stream_id_reg <= '0;
      new_reg       <= 1'b0;
      char_reg      <= '0;
      char_vld_reg  <= 1'b0;
      res_sid_reg   <= '0;
      res_new_reg   <= 1'b0;
      res_fired_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      gap_cnt_reg  <= gap_cnt_next;
      char_vld_reg <= take_char;
      if (take_key) key_reg <= bus.pkt_key;
      if (lookup) begin
        stream_id_reg <= ft_hit ? ft_hit_idx : ft_alloc_ptr;
        new_reg       <= !ft_hit;
      end
      if (take_char) char_reg <= bus.pkt_data;
      if (capture_res) begin
        res_fired_reg <= fired_in;
        res_sid_reg   <= stream_id_reg;
        res_new_reg   <= new_reg;
      end
      if (drop_beat) drop_cnt_reg <= sat_inc16(drop_cnt_reg);
    end
  end

  assign bus.pkt_rdy       = beat_rdy;
  assign bus.res_vld       = res_valid;
  assign bus.res_stream_id = res_sid_reg;
  assign bus.res_new       = res_new_reg;
  assign bus.res_fired     = res_fired_reg;
  assign stream_id         = stream_id_reg;
  assign new_stream_id     = new_reg;
  assign char_in           = char_reg;
  assign char_in_vld       = char_vld_reg;
  assign table_full        = ft_full;
  assign drop_cnt          = drop_cnt_reg;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed self-checking bench for dpi_stream_sequencer: flow lookup/eviction,
// load/char/eop timing, result back-pressure, drop counting and mid-packet reset.
module tb_dpi_stream_sequencer;

  typedef struct packed {
    logic [5:0] sid;
    logic       nw;
    logic [7:0] fired;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_state, new_stream_id, char_in_vld, eop, table_full;
  logic [5:0]  stream_id;
  logic [7:0]  char_in;
  logic [7:0]  fired_in;
  logic [7:0]  fired_pat;
  logic [15:0] drop_cnt;
  logic [63:0] all_outs;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int load_cnt = 0;
  int load_cyc = 0;
  int eop_cnt = 0;
  int eop_cyc = 0;
  int excl_bad = 0;
  logic [5:0] load_sid;
  logic       load_new;
  logic [7:0] chars[$];
  int         char_cycs[$];
  res_t       res_q[$];

  dpi_stream_sequencer_if #(.KEY_W(32), .SID_W(6), .NUM_RULES(8)) bus ();

  dpi_stream_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .load_state    (load_state),
    .stream_id     (stream_id),
    .new_stream_id (new_stream_id),
    .char_in       (char_in),
    .char_in_vld   (char_in_vld),
    .eop           (eop),
    .fired_in      (fired_in),
    .table_full    (table_full),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  // Matchers only present the pattern during eop, so a mis-timed capture shows up.
  assign fired_in = eop ? fired_pat : 8'h00;
  assign all_outs = {12'd0, load_state, stream_id, new_stream_id, char_in, char_in_vld, eop,
                     bus.res_vld, bus.res_stream_id, bus.res_new, bus.res_fired,
                     table_full, drop_cnt, bus.pkt_rdy};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load_state) begin
      load_cyc = cyc;
      load_sid = stream_id;
      load_new = new_stream_id;
      load_cnt++;
    end
    if (char_in_vld) begin
      chars.push_back(char_in);
      char_cycs.push_back(cyc);
    end
    if (eop) begin
      eop_cyc = cyc;
      eop_cnt++;
    end
    if (int'(load_state) + int'(char_in_vld) + int'(eop) > 1) excl_bad++;
    if (bus.res_vld && bus.res_rdy) res_q.push_back('{bus.res_stream_id, bus.res_new, bus.res_fired});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_chars();
    logic [63:0] v = '0;
    for (int i = 0; i < chars.size() && i < 8; i++) v[8*i +: 8] = chars[i];
    return v;
  endfunction

  function automatic int cyc_at(input int i);
    return (i >= 0 && i < char_cycs.size()) ? char_cycs[i] : -1000;
  endfunction

  task automatic clear_mon();
    chars.delete();
    char_cycs.delete();
    eop_cnt = 0;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.pkt_vld = 1'b0; bus.pkt_sop = 1'b0; bus.pkt_eop = 1'b0;
    repeat (3) @(negedge clk);
    chk(tag, all_outs, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // bytes: byte i in bits [8i+:8]; gap_len idle cycles are inserted before byte gap_at.
  task automatic send_pkt(input logic [31:0] key, input logic [63:0] bytes, input int n,
                          input int gap_at, input int gap_len);
    int i = 0;
    int bub = 0;
    int guard = 0;
    logic acc;
    @(posedge clk); #1;
    while (i < n && guard < 200) begin
      if (i == gap_at && bub < gap_len) begin
        bus.pkt_vld = 1'b0;
        bub++;
      end else begin
        bus.pkt_vld  = 1'b1;
        bus.pkt_sop  = (i == 0);
        bus.pkt_eop  = (i == n - 1);
        bus.pkt_data = bytes[8*i +: 8];
        bus.pkt_key  = key;
      end
      @(negedge clk);
      acc = bus.pkt_vld && bus.pkt_rdy;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    bus.pkt_vld = 1'b0; bus.pkt_sop = 1'b0; bus.pkt_eop = 1'b0;
    if (guard >= 200) chk("send_timeout", 64'(i), 64'(n));
  endtask

  task automatic wait_result(output res_t r);
    int n = 0;
    while (res_q.size() == 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (res_q.size() == 0) begin
      chk("res_timeout", 64'(res_q.size()), 64'd1);
      r = '0;
    end else begin
      r = res_q.pop_front();
      $display("result sid=%0d new=%0d fired=%02h", r.sid, r.nw, r.fired);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r, ra, rb;
    int load_before, eop_before, seen;
    rst_n = 1'b0;
    bus.pkt_vld = 1'b0; bus.pkt_sop = 1'b0; bus.pkt_eop = 1'b0;
    bus.pkt_data = 8'h00; bus.pkt_key = 32'h0; bus.res_rdy = 1'b1;
    fired_pat = 8'h00;
    do_reset("reset_init");

    // 1: new flow, "abc"
    clear_mon();
    send_pkt(32'hC0A80001, 64'h636261, 3, -1, 0);
    wait_result(r);
    chk("t1_load_sid", 64'(load_sid), 64'd0);
    chk("t1_load_new", 64'(load_new), 64'd1);
    chk("t1_nchars", 64'(chars.size()), 64'd3);
    chk("t1_chars", pack_chars(), 64'h636261);
    chk("t1_first_lat", 64'(cyc_at(0) - load_cyc), 64'd3);
    chk("t1_eop_lat", 64'(eop_cyc - cyc_at(2)), 64'd2);
    chk("t1_eop_cnt", 64'(eop_cnt), 64'd1);
    chk("t1_res_sid", 64'(r.sid), 64'd0);
    chk("t1_res_new", 64'(r.nw), 64'd1);
    chk("t1_res_fired", 64'(r.fired), 64'h00);

    // 2: same flow, fired pattern
    clear_mon();
    fired_pat = 8'h05;
    send_pkt(32'hC0A80001, 64'h7A, 1, -1, 0);
    wait_result(r);
    fired_pat = 8'h00;
    chk("t2_load_sid", 64'(load_sid), 64'd0);
    chk("t2_load_new", 64'(load_new), 64'd0);
    chk("t2_res_fired", 64'(r.fired), 64'h05);
    chk("t2_res_new", 64'(r.nw), 64'd0);

    // 4: bubbles mid-packet
    clear_mon();
    send_pkt(32'h0A000002, 64'h44332211, 4, 2, 2);
    wait_result(r);
    chk("t4_load_sid", 64'(load_sid), 64'd1);
    chk("t4_load_new", 64'(load_new), 64'd1);
    chk("t4_nchars", 64'(chars.size()), 64'd4);
    chk("t4_chars", pack_chars(), 64'h44332211);
    chk("t4_gap01", 64'(cyc_at(1) - cyc_at(0)), 64'd1);
    chk("t4_gap12", 64'(cyc_at(2) - cyc_at(1)), 64'd3);
    chk("t4_gap23", 64'(cyc_at(3) - cyc_at(2)), 64'd1);
    chk("t4_eop_cnt", 64'(eop_cnt), 64'd1);
    chk("t4_eop_lat", 64'(eop_cyc - cyc_at(3)), 64'd2);
    chk("t4_res_sid", 64'(r.sid), 64'd1);

    // 5: result back-pressure with a second packet waiting
    clear_mon();
    bus.res_rdy = 1'b0;
    send_pkt(32'hC0A80001, 64'h78, 1, -1, 0);
    load_before = load_cnt;
    fork
      send_pkt(32'h0A000002, 64'h6665, 2, -1, 0);
      begin
        int n = 0;
        int rdy_seen = 0;
        int held = 0;
        while (!bus.res_vld && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (10) begin
          @(negedge clk);
          if (bus.pkt_rdy) rdy_seen++;
          if (bus.res_vld) held++;
        end
        chk("t5_pkt_rdy_low", 64'(rdy_seen), 64'd0);
        chk("t5_res_held", 64'(held), 64'd10);
        chk("t5_no_load", 64'(load_cnt - load_before), 64'd0);
        @(posedge clk); #1;
        bus.res_rdy = 1'b1;
      end
    join
    wait_result(ra);
    wait_result(rb);
    chk("t5_resA_sid", 64'(ra.sid), 64'd0);
    chk("t5_resA_new", 64'(ra.nw), 64'd0);
    chk("t5_resB_sid", 64'(rb.sid), 64'd1);
    chk("t5_resB_new", 64'(rb.nw), 64'd0);
    chk("t5_B_load_sid", 64'(load_sid), 64'd1);
    chk("t5_eop_cnt", 64'(eop_cnt), 64'd2);

    // 6a: non-sop beats in IDLE are dropped
    @(posedge clk); #1;
    bus.pkt_vld = 1'b1; bus.pkt_sop = 1'b0; bus.pkt_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.pkt_vld = 1'b0;
    @(negedge clk);
    chk("t6_drop_cnt", 64'(drop_cnt), 64'd3);

    // 3: fill, evict round-robin, re-send evicted key
    do_reset("reset_t3");
    for (int j = 0; j < 65; j++) begin
      send_pkt(32'h1000_0000 + j, 64'h41, 1, -1, 0);
      wait_result(r);
      chk($sformatf("t3_sid_%0d", j), 64'(load_sid), 64'(j % 64));
      chk($sformatf("t3_new_%0d", j), 64'(r.nw), 64'd1);
      if (j == 62) chk("t3_full_after63", 64'(table_full), 64'd0);
      if (j == 63) chk("t3_full_after64", 64'(table_full), 64'd1);
    end
    send_pkt(32'h1000_0000, 64'h42, 1, -1, 0);
    wait_result(r);
    chk("t3_key1_sid", 64'(load_sid), 64'd1);
    chk("t3_key1_new", 64'(load_new), 64'd1);
    send_pkt(32'h1000_0002, 64'h43, 1, -1, 0);
    wait_result(r);
    chk("t3_key3_hit_sid", 64'(r.sid), 64'd2);
    chk("t3_key3_hit_new", 64'(r.nw), 64'd0);

    // 6b: reset in STREAM abandons the packet and clears the table
    eop_before = eop_cnt;
    @(posedge clk); #1;
    bus.pkt_vld = 1'b1; bus.pkt_sop = 1'b1; bus.pkt_eop = 1'b0;
    bus.pkt_key = 32'hDEAD0001; bus.pkt_data = 8'h55;
    seen = 0;
    for (int n = 0; n < 50 && seen == 0; n++) begin
      @(negedge clk);
      if (bus.pkt_rdy) seen = 1;
      @(posedge clk); #1;
    end
    chk("t6_reached_stream", 64'(seen), 64'd1);
    bus.pkt_sop = 1'b0;
    @(posedge clk); #1;
    do_reset("t6_reset_outs");
    repeat (20) @(posedge clk);
    #1;
    chk("t6_no_eop", 64'(eop_cnt - eop_before), 64'd0);
    chk("t6_no_result", 64'(res_q.size()), 64'd0);
    send_pkt(32'h1000_0002, 64'h44, 1, -1, 0);
    wait_result(r);
    chk("t6_after_sid", 64'(load_sid), 64'd0);
    chk("t6_after_new", 64'(load_new), 64'd1);

    chk("excl_pulses", 64'(excl_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
